siphash_msg_packer: RTL
=======================

# siphash_msg_packer

Upstream message stage for the `siphash` core. It accepts the message as a byte stream with a valid/ready handshake and packs the bytes little-endian into 64-bit message words `m_i`. It applies SipHash final-block padding: the last word carries the total message length mod 256 in its top byte. Each word is presented on a valid/ready output that the compression-round sequencer consumes, with `out_last` marking the word that must be followed by finalization.

## Interface

No parameters; all widths are fixed by SipHash.

- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `in_valid`  in  1  byte beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_data`  in  8  message byte; ignored when `in_empty`=1.
- `in_last`  in  1  beat is the final beat of the message.
- `in_empty`  in  1  zero-length message marker; valid only together with `in_last`=1; the beat carries no byte.
- `out_valid`  out  1  `out_word` holds a message word.
- `out_ready`  in  1  consumer takes the word.
- `out_word`  out  64  packed message word; byte k sits at bits [8k+7:8k].
- `out_last`  out  1  `out_word` is the padded final word.
- `busy`  out  1  a message is in progress, from its first accepted beat until the final word's handshake.

## Operation

- Internal state: accumulator `acc[63:0]`, byte index `idx[2:0]`, length counter `len[7:0]` (mod 256, wraps 255→0), output register, and the state machine.
- Beat accept condition: `in_valid & in_ready`.
- `in_ready` = `rst_n` & (state == S_ACC) & ~`out_valid`. The block inserts one bubble per emitted word; this is intentional.
- Accepted byte, `in_empty`=0: written to `acc` byte `idx`. Then `idx` increments and `len` increments.
- States:
  - S_ACC: collecting bytes.
    - Byte accepted with `idx`=7 and `in_last`=0 → S_OUT. The register is loaded with the full word, `out_last`=0.
    - Byte accepted with `idx`=7 and `in_last`=1 → S_PAD. The register is loaded with the full word, `out_last`=0.
    - Byte accepted with `idx`<7 and `in_last`=1 → S_FIN. The register is loaded with the final word: accepted bytes in bytes 0..idx, zeros above them, and byte 7 = `len`+1 (the count including this byte).
    - `in_empty` & `in_last` accepted → S_FIN with word 64'h0.
  - S_OUT: on handshake → S_ACC, `out_valid` drops.
  - S_PAD: on handshake → S_FIN. `out_word` is loaded with {`len`, 56'h0}, `out_last`=1, and `out_valid` stays high.
  - S_FIN: on handshake → S_ACC. `out_valid`, `out_last` and `busy` drop; `idx`, `len` and `acc` clear.
- `acc` clears whenever a word moves into the output register.
- `in_empty`=1 without `in_last`=1 is a protocol violation. It is treated as `in_last`=1.

## Timing

- Reset (async assert, any time): state S_ACC. `out_valid`=0, `out_word`=0, `out_last`=0, `busy`=0, `in_ready`=0 while `rst_n` is low. `idx`, `len` and `acc` clear.
- A partial message in flight at reset is discarded. The first beat after release starts a new message.
- Word latency: the beat completing a word is accepted at edge N. `out_valid`=1 with a stable `out_word` from edge N until the handshake edge.
- While `out_valid`=1 and `out_ready`=0, `out_word` and `out_last` are held and `in_ready`=0.
- A source holding `in_valid` loses no bytes.
- In S_PAD, the full word and the length word go out back-to-back: `out_valid` is continuously high across the handshake edge.
- `busy` rises on the edge accepting the first beat and falls on the S_FIN handshake edge.
- Throughput: 8 bytes per 9 cycles when the consumer is always ready.

## Test plan

- Empty message: one beat with `in_valid`=`in_last`=`in_empty`=1 → single word 64'h0000000000000000, `out_last`=1, `busy` back to 0.
- Bytes 01,02,03 with the last one marked `in_last` → 64'h0300000000030201, `out_last`=1.
- Bytes 00..07 with `in_last` on 07 → 64'h0706050403020100 with `out_last`=0, then on the next cycle 64'h0800000000000000 with `out_last`=1.
- Bytes 00..0E (15 bytes) → 64'h0706050403020100, then 64'h0F0E0D0C0B0A0908 with `out_last`=1.
- Backpressure: `out_ready`=0 for 5 cycles with `out_valid` high.
  - `out_word` is stable and `in_ready`=0 throughout.
  - The packed bytes afterwards match a randomly stalled reference model.
- Length wrap:
  - A 256-byte message ends in an extra word 64'h0000000000000000 with `out_last`=1.
  - A 257-byte message ends in a final word with byte 7 = 8'h01.
- Mid-message reset: drop `rst_n` after 5 bytes. All outputs clear asynchronously. The next 3-byte message packs with no stale bytes.

Source files
------------

// File: rtl/siphash_msg_packer_if.sv
// Byte-stream in / 64-bit message-word out bundle for the SipHash message packer.
interface siphash_msg_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_empty;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_word;
    logic        out_last;
    logic        busy;

    // Message source and word consumer side
    modport master (
        output in_valid, in_data, in_last, in_empty, out_ready,
        input  in_ready, out_valid, out_word, out_last, busy
    );

    // Packer side
    modport slave (
        input  in_valid, in_data, in_last, in_empty, out_ready,
        output in_ready, out_valid, out_word, out_last, busy
    );
endinterface

// File: rtl/siphash_msg_packer.sv
// Packs a byte stream little-endian into 64-bit SipHash message words and
// appends the final-block length byte (message length mod 256 in byte 7).
module siphash_msg_packer (
    input logic                   clk,
    input logic                   rst_n,
    siphash_msg_packer_if.slave   bus
);
    typedef enum logic [1:0] {StAcc, StOut, StPad, StFin} state_e;

    state_e      state_q;
    logic [63:0] acc_q;
    logic [63:0] word_q;
    logic [2:0]  idx_q;
    logic [7:0]  len_q;
    logic        valid_q;
    logic        last_q;
    logic        busy_q;

    logic        accept;
    logic [63:0] acc_ins;
    logic [7:0]  len_inc;

    assign bus.in_ready  = rst_n & (state_q == StAcc) & ~valid_q;
    assign bus.out_valid = valid_q;
    assign bus.out_word  = word_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = busy_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign len_inc = len_q + 8'd1;

    // Accumulator with the incoming byte dropped into lane idx
    always_comb begin
        acc_ins = acc_q;
        acc_ins[{idx_q, 3'b000} +: 8] = bus.in_data;
    end

    // Packing state machine with registered word output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAcc;
            acc_q   <= 64'h0;
            word_q  <= 64'h0;
            idx_q   <= 3'd0;
            len_q   <= 8'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        // A lone in_empty is treated as an empty final beat
                        if (bus.in_empty) begin
                            word_q  <= 64'h0;
                            last_q  <= 1'b1;
                            valid_q <= 1'b1;
                            acc_q   <= 64'h0;
                            state_q <= StFin;
                        end else if (idx_q == 3'd7) begin
                            word_q  <= acc_ins;
                            last_q  <= 1'b0;
                            valid_q <= 1'b1;
                            acc_q   <= 64'h0;
                            idx_q   <= 3'd0;
                            len_q   <= len_inc;
                            state_q <= bus.in_last ? StPad : StOut;
                        end else if (bus.in_last) begin
                            // Lanes above idx are already zero since acc clears per word
                            word_q  <= {len_inc, acc_ins[55:0]};
                            last_q  <= 1'b1;
                            valid_q <= 1'b1;
                            acc_q   <= 64'h0;
                            len_q   <= len_inc;
                            state_q <= StFin;
                        end else begin
                            acc_q <= acc_ins;
                            idx_q <= idx_q + 3'd1;
                            len_q <= len_inc;
                        end
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StAcc;
                    end
                end
                StPad: begin
                    // Length-only word follows the full word with no gap
                    if (bus.out_ready) begin
                        word_q  <= {len_q, 56'h0};
                        last_q  <= 1'b1;
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        idx_q   <= 3'd0;
                        len_q   <= 8'd0;
                        acc_q   <= 64'h0;
                        state_q <= StAcc;
                    end
                end
                default: state_q <= StAcc;
            endcase
        end
    end
endmodule
